// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
// Optional header byte per grant when UART_ARB_HEADER_EN is defined.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int MAX_WAIT_CLKS = 4096
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic [NUM_REQ-1:0]   i_Req_DV,
    input  logic [8*NUM_REQ-1:0] i_Req_Byte,
    output logic [NUM_REQ-1:0]   o_Req_Ack,
    output logic [NUM_REQ-1:0]   o_Req_Done,
    output logic                 o_TX_DV,
    output logic [7:0]           o_TX_Byte,
    input  logic                 i_TX_Active,
    input  logic                 i_TX_Done,
    output logic [2:0]           o_Grant_ID,
    output logic                 o_Busy,
    output logic                 o_Timeout
);

    localparam int CW = $clog2(MAX_WAIT_CLKS + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DONE,
`ifdef UART_ARB_HEADER_EN
        HDR_WAIT,
        HDR_GAP,
`endif
        GAP
    } state_t;

    state_t             state_reg, state_next;
    logic [2:0]         last_grant_reg, last_grant_next;
    logic [2:0]         grant_reg, grant_next;
    logic [7:0]         data_reg, data_next;
    logic [CW-1:0]      wait_cnt_reg, wait_cnt_next;
    logic [NUM_REQ-1:0] ack_reg, ack_next;
    logic [NUM_REQ-1:0] done_reg, done_next;
    logic               tx_dv_reg, tx_dv_next;
    logic [7:0]         tx_byte_reg, tx_byte_next;
    logic               timeout_reg, timeout_next;

    logic               sel_found;
    logic [2:0]         sel_idx;
    logic [7:0]         sel_byte;
    logic [NUM_REQ-1:0] sel_onehot;
    logic [NUM_REQ-1:0] grant_onehot;
    int                 cand;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign sel_onehot[gi]   = (sel_idx == 3'(gi));
            assign grant_onehot[gi] = (grant_reg == 3'(gi));
        end
    endgenerate

    // Search starts just after the last grant, so the last winner has lowest priority.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(last_grant_reg) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!sel_found && cand == k && i_Req_DV[k]) begin
                    sel_found = 1'b1;
                    sel_idx   = 3'(k);
                end
            end
        end
    end

    always_comb begin
        sel_byte = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (sel_idx == 3'(k)) sel_byte = i_Req_Byte[8*k +: 8];
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        grant_next      = grant_reg;
        data_next       = data_reg;
        wait_cnt_next   = wait_cnt_reg;
        ack_next        = '0;
        done_next       = '0;
        tx_dv_next      = 1'b0;
        tx_byte_next    = tx_byte_reg;
        timeout_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (sel_found) begin
                    grant_next    = sel_idx;
                    data_next     = sel_byte;
                    ack_next      = sel_onehot;
                    tx_dv_next    = 1'b1;
                    wait_cnt_next = '0;
`ifdef UART_ARB_HEADER_EN
                    tx_byte_next  = {4'hA, 1'b0, sel_idx};
                    state_next    = HDR_WAIT;
`else
                    tx_byte_next  = sel_byte;
                    state_next    = WAIT_DONE;
`endif
                end
            end
            WAIT_DONE: begin
                if (i_TX_Done) begin
                    done_next       = grant_onehot;
                    last_grant_next = grant_reg;
                    state_next      = GAP;
                end else if (wait_cnt_reg == CW'(MAX_WAIT_CLKS - 1)) begin
                    timeout_next    = 1'b1;
                    last_grant_next = grant_reg;
                    state_next      = IDLE;
                end else begin
                    wait_cnt_next   = wait_cnt_reg + 1'b1;
                end
            end
`ifdef UART_ARB_HEADER_EN
            HDR_WAIT: begin
                if (i_TX_Done) begin
                    state_next      = HDR_GAP;
                end else if (wait_cnt_reg == CW'(MAX_WAIT_CLKS - 1)) begin
                    timeout_next    = 1'b1;
                    last_grant_next = grant_reg;
                    state_next      = IDLE;
                end else begin
                    wait_cnt_next   = wait_cnt_reg + 1'b1;
                end
            end
            HDR_GAP: begin
                tx_dv_next    = 1'b1;
                tx_byte_next  = data_reg;
                wait_cnt_next = '0;
                state_next    = WAIT_DONE;
            end
`endif
            GAP: begin
                // Gives the transmitter one cycle to settle back to idle.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            state_reg      <= IDLE;
            last_grant_reg <= 3'(NUM_REQ - 1);
            grant_reg      <= '0;
            data_reg       <= '0;
            wait_cnt_reg   <= '0;
            ack_reg        <= '0;
            done_reg       <= '0;
            tx_dv_reg      <= 1'b0;
            tx_byte_reg    <= '0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            grant_reg      <= grant_next;
            data_reg       <= data_next;
            wait_cnt_reg   <= wait_cnt_next;
            ack_reg        <= ack_next;
            done_reg       <= done_next;
            tx_dv_reg      <= tx_dv_next;
            tx_byte_reg    <= tx_byte_next;
            timeout_reg    <= timeout_next;
        end
    end

    assign o_Req_Ack  = ack_reg;
    assign o_Req_Done = done_reg;
    assign o_TX_DV    = tx_dv_reg;
    assign o_TX_Byte  = tx_byte_reg;
    assign o_Grant_ID = grant_reg;
    assign o_Timeout  = timeout_reg;
    assign o_Busy     = (state_reg != IDLE) || i_TX_Active;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural UART transmitter/receiver loopback.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ      = 4;
    localparam int MAX_WAIT     = 64;
    localparam int CLKS_PER_BIT = 4;
    localparam int FRAME        = 10 * CLKS_PER_BIT;

    logic                 clk = 1'b0;
    logic                 rst_l;
    logic [NUM_REQ-1:0]   req_dv;
    logic [8*NUM_REQ-1:0] req_byte;
    logic [NUM_REQ-1:0]   req_ack, req_done;
    logic                 tx_dv, tx_active, tx_done, busy, timeout;
    logic [7:0]           tx_byte;
    logic [2:0]           grant_id;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .MAX_WAIT_CLKS(MAX_WAIT)) dut (
        .i_Clock(clk), .i_Rst_L(rst_l), .i_Req_DV(req_dv), .i_Req_Byte(req_byte),
        .o_Req_Ack(req_ack), .o_Req_Done(req_done), .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte),
        .i_TX_Active(tx_active), .i_TX_Done(tx_done), .o_Grant_ID(grant_id),
        .o_Busy(busy), .o_Timeout(timeout)
    );

    typedef struct {
        int         id;
        logic [7:0] b;
        bit         ack;
    } launch_t;

    launch_t    exp_launch[$];
    int         exp_done[$];
    logic [7:0] exp_rx[$];
    int         exp_timeout = 0;
    int         errors = 0, checks = 0;
    int         cyc = 0;
    bit         suppress_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Behavioural transmitter: one frame of FRAME clocks per launch, done pulse at the end.
    int         uart_cnt = 0;
    logic [7:0] uart_byte;
    always @(negedge clk) begin
        if (!rst_l) begin
            tx_active = 1'b0;
            tx_done   = 1'b0;
            uart_cnt  = 0;
        end else begin
            tx_done = 1'b0;
            if (uart_cnt > 0) begin
                uart_cnt--;
                if (uart_cnt == 0) begin
                    tx_active = 1'b0;
                    tx_done   = !suppress_done;
                    $display("rx   byte=%02h", uart_byte);
                    if (exp_rx.size() == 0) chk("rx_unexpected", 32'(uart_byte), 32'hFFFF);
                    else chk("rx_byte", 32'(uart_byte), 32'(exp_rx.pop_front()));
                end
            end else if (tx_dv) begin
                uart_byte = tx_byte;
                uart_cnt  = FRAME;
                tx_active = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a pulse.
    bit p_dv = 0, p_ack = 0, p_done = 0, p_to = 0, have_last = 0;
    int last_dv = 0;
    always @(negedge clk) begin
        if (!rst_l) begin
            p_dv = 0; p_ack = 0; p_done = 0; p_to = 0; have_last = 0;
        end else begin
            if (tx_dv) begin
                launch_t l;
                logic [NUM_REQ-1:0] e_ack;
                chk("tx_dv_single_cycle", 32'(p_dv), 32'd0);
                if (have_last) chk("launch_spacing_ok", 32'(cyc - last_dv >= FRAME + 2), 32'd1);
                $display("tx   launch id=%0d byte=%02h ack=%b", grant_id, tx_byte, req_ack);
                if (exp_launch.size() == 0) begin
                    chk("launch_unexpected", 32'(tx_byte), 32'hFFFF);
                end else begin
                    l = exp_launch.pop_front();
                    e_ack = l.ack ? (NUM_REQ'(1) << l.id) : '0;
                    chk("launch_byte", 32'(tx_byte), 32'(l.b));
                    chk("launch_grant", 32'(grant_id), 32'(l.id));
                    chk("launch_ack", 32'(req_ack), 32'(e_ack));
                end
                last_dv = cyc;
                have_last = 1;
            end else if (req_ack != 0) begin
                chk("ack_without_launch", 32'(req_ack), 32'd0);
            end
            if (req_ack != 0) chk("ack_single_cycle", 32'(p_ack), 32'd0);
            if (req_done != 0) begin
                chk("done_single_cycle", 32'(p_done), 32'd0);
                $display("done req=%b", req_done);
                if (exp_done.size() == 0) chk("done_unexpected", 32'(req_done), 32'd0);
                else chk("done_onehot", 32'(req_done), 32'(NUM_REQ'(1) << exp_done.pop_front()));
            end
            if (timeout) begin
                chk("timeout_single_cycle", 32'(p_to), 32'd0);
                $display("tmo  timeout after %0d clocks", cyc - last_dv);
                chk("timeout_expected", 32'(exp_timeout > 0), 32'd1);
                chk("timeout_latency", 32'(cyc - last_dv), 32'(MAX_WAIT));
                if (exp_timeout > 0) exp_timeout--;
            end
            p_dv = tx_dv; p_ack = (req_ack != 0); p_done = (req_done != 0); p_to = timeout;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_grant(input int k, input logic [7:0] b);
`ifdef UART_ARB_HEADER_EN
        exp_launch.push_back('{k, {4'hA, 1'b0, 3'(k)}, 1'b1});
        exp_launch.push_back('{k, b, 1'b0});
        exp_rx.push_back({4'hA, 1'b0, 3'(k)});
`else
        exp_launch.push_back('{k, b, 1'b1});
`endif
        exp_rx.push_back(b);
        exp_done.push_back(k);
    endtask

    task automatic flush();
        exp_launch.delete();
        exp_done.delete();
        exp_rx.delete();
        exp_timeout = 0;
    endtask

    task automatic drop_on_ack(input int limit);
        int n = 0;
        while (req_dv != 0 && n < limit) begin
            tick();
            n++;
            for (int k = 0; k < NUM_REQ; k++) if (req_ack[k]) req_dv[k] = 1'b0;
        end
        if (req_dv != 0) chk("ack_wait_bound", 32'(req_dv), 32'd0);
    endtask

    task automatic wait_quiet(input int limit);
        int n = 0;
        while ((exp_launch.size() != 0 || exp_done.size() != 0 || exp_rx.size() != 0 ||
                exp_timeout != 0 || busy) && n < limit) begin
            tick();
            n++;
        end
        if (n >= limit) chk("quiet_wait_bound", 32'(exp_launch.size() + exp_done.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ack"}, 32'(req_ack), 32'd0);
        chk({tag, "_done"}, 32'(req_done), 32'd0);
        chk({tag, "_tx_dv"}, 32'(tx_dv), 32'd0);
        chk({tag, "_tx_byte"}, 32'(tx_byte), 32'd0);
        chk({tag, "_grant"}, 32'(grant_id), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: got expired expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n, a0, a2;
        rst_l = 1'b0; req_dv = '0; req_byte = '0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_l = 1'b1;
        tick();

        // Single request from requester 1, one-clock launch latency.
        req_byte[15:8] = 8'h3F; req_dv[1] = 1'b1;
        push_grant(1, 8'h3F);
        n = 0;
        do begin tick(); n++; end while (!tx_dv && n < 50);
        chk("launch_latency", 32'(n), 32'd1);
        chk("single_ack", 32'(req_ack), 32'b0010);
        req_dv[1] = 1'b0;
        wait_quiet(400);
        chk("single_grant_id", 32'(grant_id), 32'd1);

        // All four from reset: round-robin order 0,1,2,3.
        rst_l = 1'b0; tick(); flush(); rst_l = 1'b1;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_byte[8*k +: 8] = 8'h10 + 8'(k);
            push_grant(k, 8'h10 + 8'(k));
        end
        req_dv = '1;
        drop_on_ack(1000);
        wait_quiet(600);

        // Fairness: req0 re-requests right after its ack while req2 stays high.
        req_byte[7:0] = 8'hA0; req_byte[23:16] = 8'h22;
        push_grant(0, 8'hA0); push_grant(2, 8'h22); push_grant(0, 8'hA1); push_grant(2, 8'h22);
        req_dv[0] = 1'b1; req_dv[2] = 1'b1;
        a0 = 0; a2 = 0; n = 0;
        while (req_dv != 0 && n < 1500) begin
            tick(); n++;
            if (req_ack[0]) begin
                a0++;
                if (a0 == 1) req_byte[7:0] = 8'hA1; else req_dv[0] = 1'b0;
            end
            if (req_ack[2]) begin
                a2++;
                if (a2 == 2) req_dv[2] = 1'b0;
            end
        end
        chk("fair_wait_bound", 32'(req_dv), 32'd0);
        wait_quiet(600);

        // Watchdog: transmitter never signals done.
        suppress_done = 1'b1;
        req_byte[31:24] = 8'h77;
`ifdef UART_ARB_HEADER_EN
        exp_launch.push_back('{3, 8'hA3, 1'b1});
        exp_rx.push_back(8'hA3);
`else
        exp_launch.push_back('{3, 8'h77, 1'b1});
        exp_rx.push_back(8'h77);
`endif
        exp_timeout = 1;
        req_dv[3] = 1'b1;
        drop_on_ack(50);
        wait_quiet(300);
        suppress_done = 1'b0;
        req_byte[15:8] = 8'h5A; req_dv[1] = 1'b1;
        push_grant(1, 8'h5A);
        drop_on_ack(50);
        wait_quiet(400);

        // Reset in the middle of a frame; afterwards requester 0 wins again.
        req_byte[23:16] = 8'h99; req_dv[2] = 1'b1;
        push_grant(2, 8'h99);
        drop_on_ack(50);
        repeat (5) tick();
        rst_l = 1'b0;
        tick();
        check_all_zero("midreset");
        flush();
        rst_l = 1'b1;
        req_byte[7:0] = 8'h01; req_byte[23:16] = 8'h02;
        push_grant(0, 8'h01); push_grant(2, 8'h02);
        req_dv[0] = 1'b1; req_dv[2] = 1'b1;
        drop_on_ack(500);
        wait_quiet(600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
